// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Provides default WIDTH/DEPTH, the XZR index and address/word typedefs.
package reg_file_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);
   localparam int XZR_INDEX = DEF_DEPTH - 1;

   typedef logic [DEF_AW-1:0]    reg_addr_t;
   typedef logic [DEF_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_multiport_word.sv
// reg_word: one WIDTH-bit enabled storage word with async active-low clear.
// Ports: clk, reset (active low), en (write enable), d (data in), q (data out).
module reg_word
   import reg_file_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] nxt;

   // AND-OR recirculation mux instead of a behavioural enable
   assign nxt = ({WIDTH{en}} & d) | ({WIDTH{~en}} & q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= '0;
      else        q <= nxt;
   end

endmodule

// File: rtl/reg_file_multiport.sv
// Multi-port register file: NUM_READ async read ports, one write port,
// per-entry busy scoreboard and optional hard-wired zero register (XZR).
// Ports: clk, reset (async active low), wr_en/wr_addr/wr_data (writeback),
//   claim_en/claim_addr (decode claim), rd_addr/rd_data/rd_busy (packed
//   read ports), busy_vec (full scoreboard).
// Build option: define REG_FILE_BYPASS_EN for same-cycle write-through.
module reg_file_multiport
   import reg_file_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int NUM_READ  = 2,
   parameter int ZERO_LAST = 1,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_en,
   input  logic [AW-1:0]             wr_addr,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      claim_en,
   input  logic [AW-1:0]             claim_addr,
   input  logic [NUM_READ*AW-1:0]    rd_addr,
   output logic [NUM_READ*WIDTH-1:0] rd_data,
   output logic [NUM_READ-1:0]       rd_busy,
   output logic [DEPTH-1:0]          busy_vec
);

   localparam int XZR = DEPTH - 1;
   localparam int NW  = (ZERO_LAST != 0) ? DEPTH - 1 : DEPTH;

   logic [WIDTH-1:0] words [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [AW-1:0]    ra;
   logic [WIDTH-1:0] rw;
   logic             rb;

   function automatic logic is_xzr(input logic [AW-1:0] a);
      return (ZERO_LAST != 0) && (a == AW'(XZR));
   endfunction

   // XZR has no storage, so writes to it fall on the floor
   genvar i;
   generate
      for (i = 0; i < NW; i++) begin : g_word
         reg_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en && (wr_addr == AW'(i))),
            .d     (wr_data),
            .q     (words[i])
         );
      end
      if (ZERO_LAST != 0) begin : g_xzr
         assign words[XZR] = '0;
      end
   endgenerate

   // Claim beats writeback: a newer producer is still in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (claim_en && claim_addr == AW'(e) && !is_xzr(AW'(e)))
               busy_q[e] <= 1'b1;
            else if (wr_en && wr_addr == AW'(e))
               busy_q[e] <= 1'b0;
         end
      end
   end

   assign busy_vec = busy_q;

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rw      = '0;
      rb      = 1'b0;
      for (int p = 0; p < NUM_READ; p++) begin
         ra = rd_addr[p*AW +: AW];
         rw = words[ra];
         rb = busy_q[ra];
`ifdef REG_FILE_BYPASS_EN
         // Reset gates the bypass so outputs stay 0 while it is held
         if (reset && wr_en && wr_addr == ra && !is_xzr(ra)) begin
            rw = wr_data;
            rb = claim_en && claim_addr == ra;
         end
`endif
         rd_data[p*WIDTH +: WIDTH] = rw;
         rd_busy[p]                = rb;
      end
   end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed self-checking bench for reg_file_multiport (NUM_READ=4).
// Covers reset, XZR, scoreboard, claim/write collision, multi-port, bypass.
module tb_reg_file_multiport;

   localparam int W  = 64;
   localparam int D  = 32;
   localparam int NR = 4;
   localparam int AW = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [W-1:0]     wr_data;
   logic             claim_en;
   logic [AW-1:0]    claim_addr;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*W-1:0]  rd_data;
   logic [NR-1:0]    rd_busy;
   logic [D-1:0]     busy_vec;

   int n_run  = 0;
   int n_fail = 0;

   reg_file_multiport #(
      .WIDTH(W), .DEPTH(D), .NUM_READ(NR), .ZERO_LAST(1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .busy_vec   (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_rd(input int a0, input int a1, input int a2,
                         input int a3);
      rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endtask

   function automatic logic [63:0] port(input int p);
      return rd_data[p*W +: W];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      wr_en    = 1'b0;
      claim_en = 1'b0;
   endtask

   initial begin
      reset      = 1'b0;
      wr_en      = 1'b1;
      wr_addr    = 5'd5;
      wr_data    = 64'hFFFF_FFFF_FFFF_FFFF;
      claim_en   = 1'b1;
      claim_addr = 5'd5;
      set_rd(5, 0, 5, 31);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_rd0", port(0), 64'h0);
      chk("rst_rd1", port(1), 64'h0);
      chk("rst_busy", {32'h0, busy_vec}, 64'h0);
      chk("rst_rdbusy", {60'h0, rd_busy}, 64'h0);

      reset    = 1'b1;
      claim_en = 1'b0;
      wr_data  = 64'hDEAD_BEEF_0000_0001;
      tick();
      chk("x5_data", port(0), 64'hDEAD_BEEF_0000_0001);
      chk("x5_busy", {32'h0, busy_vec}, 64'h0);

      wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234;
      claim_en = 1'b1; claim_addr = 5'd31;
      tick();
      set_rd(31, 31, 31, 31);
      #1;
      chk("xzr_data", port(0), 64'h0);
      chk("xzr_rdbusy", {63'h0, rd_busy[0]}, 64'h0);
      chk("xzr_busyvec", {63'h0, busy_vec[31]}, 64'h0);

      set_rd(7, 7, 7, 7);
      claim_en = 1'b1; claim_addr = 5'd7;
      tick();
      chk("sb_claim", {63'h0, busy_vec[7]}, 64'h1);
      chk("sb_rdbusy", {60'h0, rd_busy}, 64'hF);
      claim_en = 1'b1; claim_addr = 5'd7;
      tick();
      chk("sb_reclaim", {63'h0, busy_vec[7]}, 64'h1);
      tick();
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hA5;
      tick();
      chk("sb_clear", {63'h0, busy_vec[7]}, 64'h0);
      chk("sb_data", port(2), 64'hA5);

      set_rd(3, 3, 3, 3);
      wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h77;
      claim_en = 1'b1; claim_addr = 5'd3;
      tick();
      chk("sim_data", port(1), 64'h77);
      chk("sim_busy", {63'h0, busy_vec[3]}, 64'h1);
      chk("sim_rdbusy", {63'h0, rd_busy[3]}, 64'h1);

      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h42;
      tick();
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'h55;
      claim_en = 1'b1; claim_addr = 5'd10;
      tick();
      set_rd(9, 9, 9, 9);
      #1;
      for (int p = 0; p < NR; p++) chk($sformatf("mp_all%0d", p), port(p), 64'h42);
      chk("mp_all_busy", {60'h0, rd_busy}, 64'h0);
      set_rd(9, 10, 10, 9);
      #1;
      chk("mp_p0", port(0), 64'h42);
      chk("mp_p1", port(1), 64'h55);
      chk("mp_p2", port(2), 64'h55);
      chk("mp_p3", port(3), 64'h42);
      chk("mp_busy", {60'h0, rd_busy}, 64'h6);
      chk("busy_vec", {32'h0, busy_vec}, 64'h408);

      set_rd(12, 9, 10, 3);
      wr_en = 1'b1; wr_addr = 5'd12; wr_data = 64'hBEEF;
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("byp_same", port(0), 64'hBEEF);
`else
      chk("byp_same", port(0), 64'h0);
`endif
      chk("byp_busy", {63'h0, rd_busy[0]}, 64'h0);
      chk("byp_other", port(1), 64'h42);
      tick();
      chk("byp_next", port(0), 64'hBEEF);

      reset = 1'b0;
      #1;
      chk("arst_data", port(1), 64'h0);
      chk("arst_busy", {32'h0, busy_vec}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_multiport.md
Name: reg_file_multiport

Overview:
- Parametrised multi-port register file for the pipelined ARM64 core; generalises the single enabled register to DEPTH words × WIDTH bits.
- NUM_READ combinational read ports, one synchronous write port.
- Optional hard-wired zero register (XZR).
- Per-entry busy scoreboard: decode claims a destination, writeback clears it; the hazard unit reads busy flags alongside data.

Parameters:
WIDTH, 64, bits per register word
DEPTH, 32, number of registers (power of 2, ≥2)
NUM_READ, 2, number of independent read ports (1..4)
ZERO_LAST, 1, 1 = entry DEPTH-1 is hard-wired zero (XZR); 0 = ordinary entry
AW, $clog2(DEPTH), address width (derived, not to be overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (asserted at 0)
wr_en  input  1  write-enable for the writeback port
wr_addr  input  AW  writeback destination index
wr_data  input  WIDTH  writeback data
claim_en  input  1  decode marks a destination as pending
claim_addr  input  AW  index being claimed
rd_addr  input  NUM_READ*AW  packed read addresses, port p at [p*AW +: AW]
rd_data  output  NUM_READ*WIDTH  packed read data, port p at [p*WIDTH +: WIDTH]
rd_busy  output  NUM_READ  busy flag of each addressed entry
busy_vec  output  DEPTH  full scoreboard, bit i = entry i pending

Behaviour:
- Reset (reset=0, asynchronous): all words cleared to 0, all busy bits cleared. rd_data reads 0 and rd_busy/busy_vec read 0 while reset is held. Release takes effect from the next rising edge.
- Write: on a rising edge with wr_en=1, word[wr_addr] <= wr_data. Every other word holds its value; with wr_en=0, all words hold.
- Read: combinational, zero latency. rd_data port p = word[rd_addr_p]. Any number of ports may address the same entry.
- Zero register (ZERO_LAST=1):
  - Writes to DEPTH-1 are dropped and claims of DEPTH-1 are ignored.
  - Reads of DEPTH-1 return 0 and busy=0.
  - Bypass never forwards into DEPTH-1.
- Scoreboard, per entry i, evaluated each rising edge:
  - claim_en && claim_addr==i → busy[i] <= 1
  - else wr_en && wr_addr==i → busy[i] <= 0
  - else busy[i] holds
- Simultaneous claim and write to the same index: the claim wins. The word still takes wr_data and busy ends at 1, because a newer producer is in flight.
- Claiming an already-busy entry leaves it at 1. Writing a non-busy entry is legal: data is written, busy stays 0.
- rd_busy port p = busy[rd_addr_p], after the bypass adjustment below.
- All combinational outputs settle within the same cycle. No handshake stalls; the block never back-pressures.

Optional Feature:
REG_FILE_BYPASS_EN
- Defined: write-through bypass. When wr_en=1 and wr_addr==rd_addr_p (excluding the zero register), rd_data port p = wr_data in the same cycle. rd_busy port p = 0 unless claim_en && claim_addr==rd_addr_p in that same cycle.
- Undefined: reads return the stored word only; the written value is visible from the cycle after the edge, and rd_busy reflects stored busy state. The hazard unit then stalls one extra cycle.

Decomposition:
- Shared package reg_file_pkg holds:
  - default WIDTH/DEPTH constants
  - XZR_INDEX = DEPTH-1
  - typedef reg_addr_t (logic [AW-1:0])
  - typedef reg_word_t (logic [WIDTH-1:0])
- One sub-module, reg_word: a WIDTH-bit enabled word register with asynchronous active-low clear and gate-level write-enable mux. Generated DEPTH times, or DEPTH-1 times when ZERO_LAST=1.
- Scoreboard flops and read muxes stay in the top module.

Test Plan:
- Reset: hold reset=0 with wr_en=1, wr_data=64'hFFFF_FFFF_FFFF_FFFF → all reads 0, busy_vec=0. Release, write X5=64'hDEAD_BEEF_0000_0001 → X5 reads that value the next cycle.
- Zero register: write 64'h1234 to X31, claim X31 → rd_data X31 = 0, rd_busy = 0, busy_vec[31] = 0.
- Scoreboard: claim X7 at cycle n → busy_vec[7]=1 at n+1. Write X7=64'hA5 at n+3 → busy clears at n+4, data = 64'hA5.
- Simultaneous: claim X3 and write X3=64'h77 in the same cycle → next cycle X3=64'h77 and busy[3]=1.
- Multi-port: NUM_READ=4, all ports read X9=64'h42; ports 0 and 3 read X9 while ports 1 and 2 read X10=64'h55 → each port returns its own entry's data and busy.
- Bypass: write X12=64'hBEEF with rd_addr0=12 in the same cycle → with REG_FILE_BYPASS_EN, rd_data0=64'hBEEF immediately and rd_busy0=0; without it, the old value until the next edge.
